inst_fetch: RTL and testbench

Instruction fetch stage directly upstream of the decode/control unit. Issues sequential PC requests to instruction memory over a valid/ready request channel and accepts in-order responses of arbitrary latency. Buffers fetched words in a small FIFO and presents `{pc, inst}` plus pre-sliced opcode/funct3/funct7 fields to decode. On a redirect from a taken jump or branch, the stage flushes and restarts at the target.

---
 rtl/rv_pkg.sv | 19 +
 rtl/inst_fetch_if.sv | 34 +++
 rtl/inst_fetch_fifo.sv | 49 ++++
 rtl/inst_fetch.sv | 98 +++++++++
 tb/tb_inst_fetch.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared fetch-stage types and constants: widths, the NOP encoding and the default reset PC.
package rv_pkg;

  localparam int PC_W = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low bits of a target are discarded.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect from execute, and decode handoff.
interface inst_fetch_if import rv_pkg::*; ();

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [PC_W-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [INST_W-1:0] id_inst;
  logic [PC_W-1:0]   id_pc;
  logic [6:0]        id_opcode;
  logic [2:0]        id_funct3;
  logic [6:0]        id_funct7;

  // The fetch stage is the master; memory, execute and decode together form the slave side.
  modport master (
    output imem_req_valid, imem_req_addr,
    output id_valid, id_inst, id_pc, id_opcode, id_funct3, id_funct7,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  id_valid, id_inst, id_pc, id_opcode, id_funct3, id_funct7,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: synchronous circular buffer of {pc, inst} entries; flush beats push and pop.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     push_data,
  output fetch_entry_t     head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= push_data;
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != '0);

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: credit-limited sequential fetch with in-order responses, redirect flush and decode buffer.
// Optional INST_FETCH_PERF_EN adds perf_fetched / perf_flushes counters.
module inst_fetch
  import rv_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  io
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_flushes
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [PC_W-1:0]  req_pc;
  logic [PC_W-1:0]  resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] credit_used;
  logic             head_valid;
  logic             pop;
  logic             req_fire;
  logic             resp_keep;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  // An entry leaving the buffer this cycle frees its credit immediately, which keeps L=1 at full rate.
  always_comb begin
    pop               = head_valid & io.id_ready;
    credit_used       = SUM_W'(outstanding) + SUM_W'(fifo_count) - SUM_W'(pop);
    io.imem_req_valid = !rst && !io.redirect_valid && (credit_used < SUM_W'(DEPTH));
    req_fire          = io.imem_req_valid & io.imem_req_ready;
    resp_keep         = io.imem_resp_valid && (drop == '0) && !io.redirect_valid;
    push_entry        = '{pc: resp_pc, inst: io.imem_resp_data};
  end

  // On redirect every request still in flight becomes stale, so drop is reloaded rather than added to.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc      <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (io.redirect_valid) begin
      req_pc      <= align_pc(io.redirect_pc);
      resp_pc     <= align_pc(io.redirect_pc);
      outstanding <= outstanding - CNT_W'(io.imem_resp_valid);
      drop        <= outstanding - CNT_W'(io.imem_resp_valid);
    end else begin
      if (req_fire)  req_pc  <= req_pc + PC_W'(4);
      if (resp_keep) resp_pc <= resp_pc + PC_W'(4);
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(io.imem_resp_valid);
      if (io.imem_resp_valid && (drop != '0)) drop <= drop - 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (io.redirect_valid),
    .push       (resp_keep),
    .pop        (pop & ~io.redirect_valid),
    .push_data  (push_entry),
    .head_data  (head),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  assign io.imem_req_addr = req_pc;
  assign io.id_valid      = head_valid;
  assign io.id_inst       = head_valid ? head.inst : INST_NOP;
  assign io.id_pc         = head_valid ? head.pc : resp_pc;
  assign io.id_opcode     = io.id_inst[6:0];
  assign io.id_funct3     = io.id_inst[14:12];
  assign io.id_funct7     = io.id_inst[31:25];

`ifdef INST_FETCH_PERF_EN
  // A pop coinciding with a redirect is voided, so it is not counted as fetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (pop && !io.redirect_valid) perf_fetched <= perf_fetched + 32'd1;
      if (io.redirect_valid)         perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: random memory latency/backpressure/redirects against an epoch-tagged queue model.
// Also exercises INST_FETCH_PERF_EN counters when that macro is defined.
module tb_inst_fetch;
  import rv_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_fetch_if io ();

`ifdef INST_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
`ifdef INST_FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushes (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  req_t        inflight[$];
  exp_t        exp_q[$];
  int          epoch = 0;
  int          cycle = 0;
  logic [31:0] next_addr = RESET_PC;
  int          model_fetched = 0;
  int          model_flushes = 0;
  bit          model_pop;
  bit          model_req_valid;

  int          total = 0;
  int          bad = 0;

  bit          rst_cmd = 1'b1;
  int          lat_min = 1;
  int          lat_max = 1;
  int          rdy_pct = 100;
  int          idr_pct = 100;
  int          redir_pct = 0;
  bit          redir_once = 1'b0;
  logic [31:0] redir_target = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h, want %h", name, cycle, act, exp);
    end
  endtask

  task automatic apply_stimulus();
    rst = rst_cmd;
    io.redirect_valid = redir_once || ($urandom_range(0, 99) < redir_pct);
    io.redirect_pc    = redir_once ? redir_target : $urandom;
    redir_once        = 1'b0;
    io.id_ready       = ($urandom_range(0, 99) < idr_pct);
    io.imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    if (inflight.size() > 0 && inflight[0].due <= cycle) begin
      io.imem_resp_valid = 1'b1;
      io.imem_resp_data  = mem_word(inflight[0].addr);
    end else begin
      io.imem_resp_valid = 1'b0;
      io.imem_resp_data  = $urandom;
    end
  endtask

  // Model view: buffer = queue of kept words, in-flight = queue of requests tagged with the epoch they belong to.
  task automatic check_output();
    exp_t e;
    model_pop       = (exp_q.size() > 0) && io.id_ready;
    model_req_valid = !rst && !io.redirect_valid &&
                      (inflight.size() + exp_q.size() - int'(model_pop) < DEPTH);
    check("req_valid", io.imem_req_valid, model_req_valid);
    if (model_req_valid) check("req_addr", io.imem_req_addr, next_addr);
    check("id_valid", io.id_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check("id_pc", io.id_pc, e.pc);
      check("id_inst", io.id_inst, e.inst);
      check("id_opcode", io.id_opcode, e.inst & 32'h7F);
      check("id_funct3", io.id_funct3, (e.inst >> 12) & 32'h7);
      check("id_funct7", io.id_funct7, e.inst >> 25);
    end else begin
      check("id_inst_nop", io.id_inst, INST_NOP);
    end
`ifdef INST_FETCH_PERF_EN
    check("perf_fetched", perf_fetched, model_fetched);
    check("perf_flushes", perf_flushes, model_flushes);
`endif
  endtask

  task automatic model_update();
    req_t r;
    if (rst) begin
      inflight.delete();
      exp_q.delete();
      next_addr     = RESET_PC;
      epoch++;
      model_fetched = 0;
      model_flushes = 0;
    end else begin
      if (io.redirect_valid) begin
        epoch++;
        exp_q.delete();
        next_addr = {io.redirect_pc[31:2], 2'b00};
        model_flushes++;
      end else if (model_pop) begin
        void'(exp_q.pop_front());
        model_fetched++;
      end
      if (io.imem_resp_valid) begin
        r = inflight.pop_front();
        if (r.epoch == epoch) exp_q.push_back('{pc: r.addr, inst: io.imem_resp_data});
      end
      if (model_req_valid && io.imem_req_ready) begin
        inflight.push_back('{addr: next_addr, epoch: epoch,
                             due: cycle + int'($urandom_range(lat_min, lat_max))});
        next_addr = next_addr + 32'd4;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    apply_stimulus();
    #1;
    check_output();
    model_update();
    cycle++;
  endtask

  task automatic do_reset();
    rst_cmd = 1'b1;
    step();
    rst_cmd = 1'b0;
  endtask

  initial begin
    int          fires;
    bit          found;
    logic [31:0] wa;

    rst = 1'b1;
    io.redirect_valid  = 1'b0;
    io.redirect_pc     = '0;
    io.id_ready        = 1'b0;
    io.imem_req_ready  = 1'b0;
    io.imem_resp_valid = 1'b0;
    io.imem_resp_data  = '0;

    step();
    check("rst_id_valid", io.id_valid, 0);
    check("rst_id_inst", io.id_inst, 32'h0000_0013);
    check("rst_id_pc", io.id_pc, RESET_PC);
    check("rst_req_valid", io.imem_req_valid, 0);
    rst_cmd = 1'b0;

    // Free-run at L=1: one instruction per cycle starting two cycles after the first request.
    for (int k = 0; k < 6; k++) begin
      step();
      if (k >= 2 && k <= 4) begin
        check("free_valid", io.id_valid, 1);
        check("free_pc", io.id_pc, 32'(4 * (k - 2)));
      end
    end

    // Decode stalled: only DEPTH requests may be accepted, then drain in order.
    do_reset();
    idr_pct = 0;
    fires = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (io.imem_req_valid && io.imem_req_ready) fires++;
    end
    check("bp_fires", fires, 4);
    check("bp_head_valid", io.id_valid, 1);
    check("bp_head_pc", io.id_pc, 32'h0);
    idr_pct = 100;
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_drain_pc", io.id_pc, 32'(4 * k));
    end

    // Redirect with three requests in flight at L=3.
    do_reset();
    lat_min = 3;
    lat_max = 3;
    for (int k = 0; k < 3; k++) step();
    rdy_pct      = 0;
    redir_once   = 1'b1;
    redir_target = 32'h100;
    step();
    rdy_pct = 100;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (io.id_valid) begin
        check("redir_first_pc", io.id_pc, 32'h100);
        check("redir_latency", i + 1, 5);
        found = 1'b1;
      end
    end
    if (!found) check("redir_timeout", 0, 1);

    // Redirect landing on a response and a pop, with a misaligned target.
    lat_min = 1;
    lat_max = 1;
    for (int k = 0; k < 6; k++) step();
    redir_once   = 1'b1;
    redir_target = 32'h203;
    step();
    step();
    check("flush_id_valid", io.id_valid, 0);
    check("misalign_valid", io.imem_req_valid, 1);
    check("misalign_addr", io.imem_req_addr, 32'h200);

    // Sequential wrap at the top of the address space.
    redir_once   = 1'b1;
    redir_target = 32'hFFFF_FFF8;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      wa = 32'hFFFF_FFF8 + 32'(4 * k);
      check("wrap_addr", io.imem_req_addr, wa);
    end

    // Random traffic with a reset in the middle.
    lat_min   = 1;
    lat_max   = 4;
    rdy_pct   = 70;
    idr_pct   = 60;
    redir_pct = 4;
    for (int i = 0; i < 3000; i++) begin
      rst_cmd = (i >= 1500 && i < 1502);
      step();
    end
    rst_cmd   = 1'b0;
    lat_max   = 6;
    rdy_pct   = 90;
    idr_pct   = 90;
    redir_pct = 1;
    for (int i = 0; i < 1500; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
